// File: rtl/subseq_trace_decoder.sv
// subseq_trace_decoder
// Registers the decoded sub-sequence word (PINC/MINC strobes, active-low
// one-hot bus, binary index, change pulse) and, when SUBSEQ_TRACE_EN is
// defined, logs every index change with a timestamp into a first-word-
// fall-through trace FIFO for the debug/monitor path.
// Build option: define SUBSEQ_TRACE_EN to compile the trace FIFO and
// timestamp; otherwise the TRC_* outputs are tied to their idle values.
`timescale 1ns/1ps

module subseq_trace_decoder #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 11
) (
  input  logic                      CLK2,
  input  logic                      RESET,
  input  logic [7:0]                SUBSEQ,
  output logic                      PINC,
  output logic                      MINC,
  output logic [19:0]               NSUBSQ,
  output logic [4:0]                SEQ_IDX,
  output logic                      SEQ_CHG,
  input  logic                      TRC_CLR,
  input  logic                      TRC_RD,
  output logic [5+TS_W-1:0]         TRC_DATA,
  output logic                      TRC_EMPTY,
  output logic                      TRC_FULL,
  output logic [$clog2(DEPTH):0]    TRC_CNT,
  output logic                      TRC_OVF
);

  localparam logic [4:0] NOSEQ = 5'd31;

  // Key layout: stage = {STB_1,STB_0}, code = SQ. Unlisted keys are NOSEQ.
  function automatic logic [4:0] decode_idx(input logic [5:0] key);
    logic [4:0] idx;
    case ({key[1:0], key[5:2]})
      6'b00_0000: idx = 5'd0;   // TC0
      6'b00_0001: idx = 5'd1;   // CCS0
      6'b00_0010: idx = 5'd2;   // CCS1
      6'b00_0011: idx = 5'd3;   // NDX0
      6'b00_1001: idx = 5'd4;   // NDX1
      6'b00_1010: idx = 5'd5;   // RSM3
      6'b00_1011: idx = 5'd6;   // XCH0
      6'b00_1100: idx = 5'd7;   // CS0
      6'b00_1101: idx = 5'd8;   // TS0
      6'b00_1110: idx = 5'd9;   // AD0
      6'b00_1111: idx = 5'd10;  // MASK0
      6'b01_0000: idx = 5'd11;  // MP0
      6'b01_0001: idx = 5'd12;  // MP1
      6'b01_0010: idx = 5'd13;  // MP3
      6'b01_1001: idx = 5'd14;  // DV0
      6'b01_1010: idx = 5'd15;  // DV1
      6'b10_0000: idx = 5'd16;  // SU0
      6'b10_0011: idx = 5'd17;  // RUPT1
      6'b10_1010: idx = 5'd18;  // RUPT3
      6'b10_1011: idx = 5'd19;  // STD2
      default:    idx = NOSEQ;
    endcase
    return idx;
  endfunction

  // Active-low one-hot expansion; NOSEQ (and any index >= 20) gives all ones.
  function automatic logic [19:0] onehot_low(input logic [4:0] idx);
    logic [19:0] v;
    for (int i = 0; i < 20; i++) begin
      v[i] = (idx != 5'(i));
    end
    return v;
  endfunction

  logic [4:0]  w_idx_p0;
  logic        w_chg_p0;
  logic [4:0]  r_idx_p1;
  logic [19:0] r_nsub_p1;
  logic        r_pinc_p1;
  logic        r_minc_p1;
  logic        r_chg_p1;

  assign w_idx_p0 = decode_idx(SUBSEQ[5:0]);
  assign w_chg_p0 = (w_idx_p0 != r_idx_p1);

  // ---- stage p0 -> p1: decode register ----
  // Registers decoded index, one-hot bus, strobes and change pulse.
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      r_idx_p1  <= NOSEQ;
      r_nsub_p1 <= '1;
      r_pinc_p1 <= 1'b1;
      r_minc_p1 <= 1'b1;
      r_chg_p1  <= 1'b0;
    end else begin
      r_idx_p1  <= w_idx_p0;
      r_nsub_p1 <= onehot_low(w_idx_p0);
      r_pinc_p1 <= ~(SUBSEQ[6] & ~SUBSEQ[7]);
      r_minc_p1 <= ~(~SUBSEQ[6] & SUBSEQ[7]);
      r_chg_p1  <= w_chg_p0;
    end
  end

  assign PINC    = r_pinc_p1;
  assign MINC    = r_minc_p1;
  assign NSUBSQ  = r_nsub_p1;
  assign SEQ_IDX = r_idx_p1;
  assign SEQ_CHG = r_chg_p1;

`ifdef SUBSEQ_TRACE_EN
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 5 + TS_W;

  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_ts_chg_p1;
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_full;
  logic             w_rd;
  logic             w_push;
  logic             w_drop;

  assign w_full = (r_cnt == CNT_W'(DEPTH));
  assign w_rd   = TRC_RD && (r_cnt != '0);
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_push = r_chg_p1 && (!w_full || w_rd);
  assign w_drop = r_chg_p1 && w_full && !w_rd;

  // Free-running timestamp; TRC_CLR restarts it at zero.
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      r_ts <= '0;
    end else if (TRC_CLR) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  // Capture the timestamp on the edge the new index registers; the entry
  // itself is written one edge later from the registered change pulse.
  always_ff @(posedge CLK2) begin
    if (w_chg_p0) begin
      r_ts_chg_p1 <= r_ts;
    end
  end

  // ---- stage p1 -> p2: trace FIFO write ----
  // Pointer, count and overflow control; clear overrides push and pop.
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else if (TRC_CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_rd)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_rd) r_cnt <= r_cnt - 1'b1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Entry storage; contents are qualified by the count, so no reset needed.
  always_ff @(posedge CLK2) begin
    if (w_push && !TRC_CLR) begin
      r_mem[r_wr_ptr] <= {r_idx_p1, r_ts_chg_p1};
    end
  end

  assign TRC_DATA  = (r_cnt != '0) ? r_mem[r_rd_ptr] : '0;
  assign TRC_EMPTY = (r_cnt == '0);
  assign TRC_FULL  = w_full;
  assign TRC_CNT   = r_cnt;
  assign TRC_OVF   = r_ovf;
`else
  logic w_unused;

  assign w_unused  = &{1'b0, TRC_CLR, TRC_RD};
  assign TRC_DATA  = '0;
  assign TRC_EMPTY = 1'b1;
  assign TRC_FULL  = 1'b0;
  assign TRC_CNT   = '0;
  assign TRC_OVF   = 1'b0;
`endif

endmodule

// File: tb/tb_subseq_trace_decoder.sv
// Directed bench for subseq_trace_decoder: decode sweep, strobes, and
// (with SUBSEQ_TRACE_EN) trace ordering, overflow, clear priority; reset
// mid-operation in both builds.
`timescale 1ns/1ps

module tb_subseq_trace_decoder;

  localparam int DEPTH = 4;
  localparam int TS_W  = 11;

  logic        CLK2 = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  SUBSEQ = 8'h03;
  logic        TRC_CLR = 1'b0;
  logic        TRC_RD = 1'b0;
  logic        PINC, MINC, SEQ_CHG;
  logic [19:0] NSUBSQ;
  logic [4:0]  SEQ_IDX;
  logic [15:0] TRC_DATA;
  logic        TRC_EMPTY, TRC_FULL, TRC_OVF;
  logic [2:0]  TRC_CNT;

  subseq_trace_decoder #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .CLK2(CLK2), .RESET(RESET), .SUBSEQ(SUBSEQ),
    .PINC(PINC), .MINC(MINC), .NSUBSQ(NSUBSQ), .SEQ_IDX(SEQ_IDX),
    .SEQ_CHG(SEQ_CHG), .TRC_CLR(TRC_CLR), .TRC_RD(TRC_RD),
    .TRC_DATA(TRC_DATA), .TRC_EMPTY(TRC_EMPTY), .TRC_FULL(TRC_FULL),
    .TRC_CNT(TRC_CNT), .TRC_OVF(TRC_OVF)
  );

  always #5 CLK2 = ~CLK2;

  int n_tests = 0;
  int n_fail  = 0;

  // SUBSEQ[5:0] values of indices 0..19, written out from the key map.
  logic [5:0] valid_keys [20] = '{
    6'h00, 6'h04, 6'h08, 6'h0C, 6'h24, 6'h28, 6'h2C, 6'h30, 6'h34, 6'h38,
    6'h3C, 6'h01, 6'h05, 6'h09, 6'h25, 6'h29, 6'h02, 6'h0E, 6'h2A, 6'h2E
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK2);
    #1;
  endtask

  function automatic logic [4:0] ref_idx(input logic [7:0] s);
    for (int i = 0; i < 20; i++) begin
      if (s[5:0] == valid_keys[i]) return 5'(i);
    end
    return 5'd31;
  endfunction

  function automatic logic [19:0] ref_nsub(input logic [4:0] idx);
    if (idx == 5'd31) return 20'hFFFFF;
    return ~(20'd1 << idx);
  endfunction

  function automatic logic [15:0] ent(input int idx, input int ts);
    return {5'(idx), 11'(ts)};
  endfunction

  task automatic check_tied(input string tag);
    check({tag, "_empty"}, TRC_EMPTY, 1);
    check({tag, "_full"},  TRC_FULL, 0);
    check({tag, "_cnt"},   TRC_CNT, 0);
    check({tag, "_ovf"},   TRC_OVF, 0);
    check({tag, "_data"},  TRC_DATA, 0);
  endtask

  logic [4:0] prev;
  logic [4:0] e;
  logic [7:0] sb_pat [4]  = '{8'h40, 8'h80, 8'h00, 8'hC0};
  logic       pinc_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic       minc_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] ovf_seq [6]  = '{8'h00, 8'h04, 8'h00, 8'h04, 8'h00, 8'h04};
  logic [15:0] drain_exp [4];

  initial begin
    // Reset values while RESET is held
    #2 RESET = 1'b1;
    #1;
    check("rst_pinc", PINC, 1);
    check("rst_minc", MINC, 1);
    check("rst_nsub", NSUBSQ, 20'hFFFFF);
    check("rst_idx",  SEQ_IDX, 31);
    check("rst_chg",  SEQ_CHG, 0);
    check_tied("rst");
    @(posedge CLK2);
    @(posedge CLK2);
    #2 RESET = 1'b0;

    // Full decode sweep with SB=00; first key also checks change from 31
    prev = 5'd31;
    for (int k = 0; k < 64; k++) begin
      SUBSEQ = 8'(k);
      tick();
      e = ref_idx(SUBSEQ);
      check($sformatf("sweep_idx_k%0d", k), SEQ_IDX, e);
      check($sformatf("sweep_nsub_k%0d", k), NSUBSQ, ref_nsub(e));
      check($sformatf("sweep_chg_k%0d", k), SEQ_CHG, (e != prev));
      prev = e;
    end

    // PINC/MINC for each SB_02:SB_01 pattern; decode ignores SB bits
    for (int p = 0; p < 4; p++) begin
      SUBSEQ = sb_pat[p];
      tick();
      check($sformatf("pinc_p%0d", p), PINC, pinc_exp[p]);
      check($sformatf("minc_p%0d", p), MINC, minc_exp[p]);
      check($sformatf("sb_idx_p%0d", p), SEQ_IDX, 0);
    end

`ifdef SUBSEQ_TRACE_EN
    // Trace ordering: TC0 x3, CCS0 x1, NOSEQ -> (0,0) (1,3) (31,4)
    SUBSEQ = 8'h03;
    tick();
    tick();
    TRC_CLR = 1'b1;
    tick();
    TRC_CLR = 1'b0;
    check("clr_cnt", TRC_CNT, 0);
    check("clr_ovf", TRC_OVF, 0);
    check("clr_empty", TRC_EMPTY, 1);
    SUBSEQ = 8'h00;
    tick();
    check("ord_nobypass", TRC_EMPTY, 1);
    tick();
    check("ord_cnt1", TRC_CNT, 1);
    check("ord_head0", TRC_DATA, ent(0, 0));
    tick();
    SUBSEQ = 8'h04;
    tick();
    SUBSEQ = 8'h03;
    tick();
    tick();
    check("ord_cnt3", TRC_CNT, 3);
    TRC_RD = 1'b1;
    tick();
    check("ord_pop1", TRC_DATA, ent(1, 3));
    tick();
    check("ord_pop2", TRC_DATA, ent(31, 4));
    tick();
    TRC_RD = 1'b0;
    check("ord_empty", TRC_EMPTY, 1);
    check("ord_data0", TRC_DATA, 0);
    check("ord_cnt0", TRC_CNT, 0);

    // Overflow: six changes into a 4-deep FIFO, then push+pop when full
    TRC_CLR = 1'b1;
    tick();
    TRC_CLR = 1'b0;
    for (int i = 0; i < 6; i++) begin
      SUBSEQ = ovf_seq[i];
      tick();
    end
    tick();
    check("ovf_full", TRC_FULL, 1);
    check("ovf_cnt", TRC_CNT, 4);
    check("ovf_flag", TRC_OVF, 1);
    check("ovf_head", TRC_DATA, ent(0, 0));
    SUBSEQ = 8'h00;
    tick();
    TRC_RD = 1'b1;
    tick();
    TRC_RD = 1'b0;
    check("ovf_rdw_cnt", TRC_CNT, 4);
    check("ovf_rdw_full", TRC_FULL, 1);
    check("ovf_rdw_head", TRC_DATA, ent(1, 1));
    drain_exp = '{ent(0, 2), ent(1, 3), ent(0, 7), 16'h0000};
    TRC_RD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ovf_drain%0d", i), TRC_DATA, drain_exp[i]);
    end
    TRC_RD = 1'b0;
    check("ovf_drain_empty", TRC_EMPTY, 1);
    check("ovf_sticky", TRC_OVF, 1);

    // Clear coincident with SEQ_CHG and TRC_RD
    SUBSEQ = 8'h04;
    tick();
    tick();
    check("cp_pre_cnt", TRC_CNT, 1);
    SUBSEQ = 8'h08;
    tick();
    check("cp_pre_chg", SEQ_CHG, 1);
    TRC_CLR = 1'b1;
    TRC_RD  = 1'b1;
    tick();
    TRC_CLR = 1'b0;
    TRC_RD  = 1'b0;
    check("cp_cnt", TRC_CNT, 0);
    check("cp_ovf", TRC_OVF, 0);
    check("cp_empty", TRC_EMPTY, 1);
    check("cp_idx", SEQ_IDX, 2);
    SUBSEQ = 8'h0C;
    tick();
    check("cp_idx_next", SEQ_IDX, 3);
    check("cp_chg_next", SEQ_CHG, 1);
    tick();
    check("cp_ts0_entry", TRC_DATA, ent(3, 0));
    check("cp_cnt1", TRC_CNT, 1);

    // Build up three entries before the asynchronous reset
    SUBSEQ = 8'h00;
    tick();
    SUBSEQ = 8'h04;
    tick();
    SUBSEQ = 8'h44;
    tick();
    check("mid_cnt3", TRC_CNT, 3);
`else
    // Trace outputs stay tied regardless of clear, read and changes
    SUBSEQ  = 8'h00;
    TRC_CLR = 1'b1;
    TRC_RD  = 1'b1;
    tick();
    check_tied("tied_a");
    TRC_CLR = 1'b0;
    SUBSEQ  = 8'h04;
    tick();
    tick();
    check_tied("tied_b");
    TRC_RD = 1'b0;
    SUBSEQ = 8'h44;
    tick();
`endif

    // Asynchronous reset between edges
    check("mid_pre_pinc", PINC, 0);
    check("mid_pre_idx", SEQ_IDX, 1);
    #3 RESET = 1'b1;
    #1;
    check("mid_pinc", PINC, 1);
    check("mid_minc", MINC, 1);
    check("mid_nsub", NSUBSQ, 20'hFFFFF);
    check("mid_idx", SEQ_IDX, 31);
    check("mid_chg", SEQ_CHG, 0);
    check_tied("mid");
    #3 RESET = 1'b0;
    tick();
    check("post_idx", SEQ_IDX, 1);
    check("post_chg", SEQ_CHG, 1);
    check("post_nsub", NSUBSQ, 20'hFFFFD);
    tick();
`ifdef SUBSEQ_TRACE_EN
    check("post_cnt", TRC_CNT, 1);
    check("post_entry", TRC_DATA, ent(1, 0));
`else
    check_tied("post");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/subseq_trace_decoder.md
# subseq_trace_decoder

Registered, parametrised sub-sequence decoder with change detection and a debug trace FIFO. It samples the 8-bit sub-sequence word once per clock. It produces registered PINC/MINC strobes, a registered active-low one-hot sub-sequence bus and a binary sub-sequence index. Every sub-sequence transition is logged with a timestamp into a readable FIFO. It sits beside the CPM control-pulse logic and feeds the debug/monitor path; it never drives control pulses.

## Interface
- DEPTH, 16, trace FIFO entries; power of two, ≥2
- TS_W, 11, timestamp counter width
- CLK2  in  1  system clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- SUBSEQ  in  8  sub-sequence word: [7]=SB_02, [6]=SB_01, [5:2]=SQ, [1]=STB_1, [0]=STB_0
- PINC  out  1  registered, active-low: 0 when SB_01=1 and SB_02=0
- MINC  out  1  registered, active-low: 0 when SB_01=0 and SB_02=1
- NSUBSQ  out  20  registered, active-low one-hot; bit k low when index=k
- SEQ_IDX  out  5  registered index 0–19; 31 = NOSEQ
- SEQ_CHG  out  1  one-cycle pulse when SEQ_IDX changed on this edge
- TRC_CLR  in  1  synchronous clear: trace FIFO, overflow flag, timestamp
- TRC_RD  in  1  pop head entry; ignored when TRC_EMPTY
- TRC_DATA  out  5+TS_W  head entry {idx[4:0], ts[TS_W-1:0]}; first-word-fall-through
- TRC_EMPTY  out  1  FIFO empty
- TRC_FULL  out  1  FIFO holds DEPTH entries
- TRC_CNT  out  $clog2(DEPTH)+1  entry count
- TRC_OVF  out  1  sticky: an entry was dropped

## Operation
- Decode key {SQ,STB_1,STB_0}. Mapping, key→index:
  - stage 00: 0000→0 TC0, 0001→1 CCS0, 0010→2 CCS1, 0011→3 NDX0, 1001→4 NDX1, 1010→5 RSM3, 1011→6 XCH0, 1100→7 CS0, 1101→8 TS0, 1110→9 AD0, 1111→10 MASK0
  - stage 01: 0000→11 MP0, 0001→12 MP1, 0010→13 MP3, 1001→14 DV0, 1010→15 DV1
  - stage 10: 0000→16 SU0, 0011→17 RUPT1, 1010→18 RUPT3, 1011→19 STD2
  - All other keys, including any stage 11: index 31, NSUBSQ all ones.
- NSUBSQ is exactly the one-hot-low expansion of SEQ_IDX. It is never multi-hot.
- Change detect: SEQ_CHG=1 when new index ≠ previous registered index. NOSEQ transitions count as changes.
- Timestamp is a free-running TS_W counter, +1 per clock, wrapping modulo 2^TS_W. The logged ts is the counter value on the edge the new index registers.
- Trace write occurs on every SEQ_CHG.
  - Full with no read: the entry is dropped and TRC_OVF is set.
  - Full with simultaneous TRC_RD: pop and push both occur, count is unchanged, no overflow.
- Read: TRC_RD while not empty advances the head. TRC_DATA shows the next entry, or 0 when empty.
- Write on an empty FIFO: TRC_DATA is valid on the following cycle. There is no bypass.
- TRC_CLR has priority over write and read in the same cycle.
  - It empties the FIFO, clears TRC_OVF and zeroes the timestamp.
  - It does not affect the decode registers or SEQ_CHG.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is tracked separately.

## Timing
- Latency is 1 clock: SUBSEQ sampled at edge n appears on PINC/MINC/NSUBSQ/SEQ_IDX/SEQ_CHG after edge n.
- FIFO entry is visible on TRC_DATA one clock after SEQ_CHG.
- Reset (asynchronous, any time, including mid-write or mid-read) forces:
  - PINC=1, MINC=1, NSUBSQ=20'hFFFFF, SEQ_IDX=31, SEQ_CHG=0
  - FIFO empty, TRC_DATA=0, TRC_EMPTY=1, TRC_FULL=0, TRC_CNT=0, TRC_OVF=0, timestamp=0
- First clock after reset with a valid key: SEQ_CHG=1, since the index changes from 31.

## Configuration
- SUBSEQ_TRACE_EN defined: trace FIFO, timestamp and TRC_* behaviour as above.
- SUBSEQ_TRACE_EN undefined: FIFO and timestamp logic are not compiled. Outputs are tied: TRC_EMPTY=1, TRC_FULL=0, TRC_CNT=0, TRC_OVF=0, TRC_DATA=0. TRC_CLR and TRC_RD are ignored. Decode outputs and SEQ_CHG are unchanged.

## Test plan
- Full decode sweep: drive all 64 keys with SB=00 for one clock each. Each valid key gives SEQ_IDX per map and a single low NSUBSQ bit one clock later (e.g. 0x38 key 1110_00 → idx 9, NSUBSQ=20'hFFDFF). Invalid keys give 31 / 20'hFFFFF.
- PINC/MINC: SB_02:SB_01 = 01 → PINC=0, MINC=1; 10 → PINC=1, MINC=0; 00 and 11 → both 1. Each is registered one clock later.
- Trace ordering: after reset and TRC_CLR, hold TC0 3 clocks, CCS0 1 clock, then NOSEQ. FIFO holds idx 0, 1, 31 with ts 0, 3, 4. Pop three times; TRC_EMPTY=1.
- Overflow: DEPTH=4, alternate TC0/CCS0 every clock for 6 changes, no reads. TRC_FULL=1, TRC_CNT=4, TRC_OVF=1, first 4 entries retained. Next change with TRC_RD=1: count stays 4, no data loss.
- Clear priority: TRC_CLR coincident with SEQ_CHG and TRC_RD. Next cycle TRC_CNT=0, TRC_OVF=0, ts=0, SEQ_IDX updated normally.
- Reset mid-operation: assert RESET asynchronously between edges with FIFO at 3 entries. All outputs take reset values immediately. Build with SUBSEQ_TRACE_EN undefined and confirm TRC_* stay tied.
